// File: rtl/ads8528_capture.sv
// ads8528_capture
// Acquisition sequencer for an ADS8528 in parallel-bus, simultaneous-sampling
// mode. A free-running period timer starts a conversion (CONVST pulse). The
// block then waits for BUSY to rise and fall, reads CHANNELS words over the
// CS/RD bus, and pushes each word into the sample FIFO as a one-cycle write.
//
// Ports
//   clk, rst           system clock, synchronous active-low reset
//   enable             run the period timer / accept new conversions
//   clear_flags        one-cycle pulse clearing overrun and timeout
//   adc_busy           raw ADC BUSY pin (synchronized internally)
//   adc_db             ADC parallel data bus
//   adc_convst         conversion start, active high
//   adc_cs_n/adc_rd_n  chip select / read strobe, active low
//   fifo_full          sample FIFO full flag
//   fifo_write         one-cycle FIFO write strobe
//   fifo_data          registered sample, valid with fifo_write
//   overrun, timeout   sticky status flags
//   active             FSM is outside IDLE
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for the period trigger
// CONVST   | adc_convst held high for CONVST_CYC cycles
// WAIT_BH  | waiting for synchronized BUSY to rise (bounded)
// WAIT_BL  | waiting for synchronized BUSY to fall (bounded)
// RD_LO    | cs_n=0, rd_n=0 for RD_LOW_CYC cycles; word captured at end
// RD_HI    | cs_n=0, rd_n=1 for RD_HIGH_CYC cycles; FIFO push decided
module ads8528_capture #(
  parameter int CHANNELS     = 8,
  parameter int DATA_WIDTH   = 16,
  parameter int SAMPLE_DIV   = 1000,
  parameter int CONVST_CYC   = 4,
  parameter int RD_LOW_CYC   = 3,
  parameter int RD_HIGH_CYC  = 2,
  parameter int BUSY_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  clear_flags,
  input  logic                  adc_busy,
  input  logic [DATA_WIDTH-1:0] adc_db,
  output logic                  adc_convst,
  output logic                  adc_cs_n,
  output logic                  adc_rd_n,
  input  logic                  fifo_full,
  output logic                  fifo_write,
  output logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  overrun,
  output logic                  timeout,
  output logic                  active
);

  localparam int TW = $clog2(SAMPLE_DIV);
  localparam int CNT_MAX = (CONVST_CYC > RD_LOW_CYC)
                         ? ((CONVST_CYC > RD_HIGH_CYC) ? CONVST_CYC : RD_HIGH_CYC)
                         : ((RD_LOW_CYC > RD_HIGH_CYC) ? RD_LOW_CYC : RD_HIGH_CYC);
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int WW = $clog2(BUSY_TIMEOUT + 1);
  localparam int HW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [TW-1:0] TIMER_LAST  = TW'(SAMPLE_DIV - 1);
  localparam logic [CW-1:0] CONVST_LOAD = CW'(CONVST_CYC - 1);
  localparam logic [CW-1:0] RDLO_LOAD   = CW'(RD_LOW_CYC - 1);
  localparam logic [CW-1:0] RDHI_LOAD   = CW'(RD_HIGH_CYC - 1);
  localparam logic [WW-1:0] WAIT_LAST   = WW'(BUSY_TIMEOUT);
  localparam logic [HW-1:0] CH_LAST     = HW'(CHANNELS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CONVST, S_WAIT_BH, S_WAIT_BL, S_RD_LO, S_RD_HI
  } state_t;

  state_t                  state_q, state_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [WW-1:0]           wait_q, wait_d;
  logic [HW-1:0]           ch_q, ch_d;
  logic                    busy_s1_q, busy_s1_d, busy_s2_q, busy_s2_d;
  logic                    convst_q, convst_d, cs_n_q, cs_n_d, rd_n_q, rd_n_d;
  logic                    write_q, write_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    overrun_q, overrun_d, timeout_q, timeout_d;
  logic                    active_q, active_d;
  logic                    trigger, set_ovr, set_to;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      cnt_q     <= '0;
      wait_q    <= '0;
      ch_q      <= '0;
      busy_s1_q <= 1'b0;
      busy_s2_q <= 1'b0;
      convst_q  <= 1'b0;
      cs_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
      write_q   <= 1'b0;
      data_q    <= '0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      cnt_q     <= cnt_d;
      wait_q    <= wait_d;
      ch_q      <= ch_d;
      busy_s1_q <= busy_s1_d;
      busy_s2_q <= busy_s2_d;
      convst_q  <= convst_d;
      cs_n_q    <= cs_n_d;
      rd_n_q    <= rd_n_d;
      write_q   <= write_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
      active_q  <= active_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wait_d    = wait_q;
    ch_d      = ch_q;
    data_d    = data_q;
    write_d   = 1'b0;
    set_ovr   = 1'b0;
    set_to    = 1'b0;
    busy_s1_d = adc_busy;
    busy_s2_d = busy_s1_q;

    trigger = enable && (timer_q == TIMER_LAST);
    if (!enable || trigger) timer_d = '0;
    else                    timer_d = timer_q + TW'(1);

    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          state_d = S_CONVST;
          cnt_d   = CONVST_LOAD;
        end
      end
      S_CONVST: begin
        if (cnt_q == '0) begin
          state_d = S_WAIT_BH;
          wait_d  = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_WAIT_BH: begin
        if (busy_s2_q) begin
          state_d = S_WAIT_BL;
          wait_d  = '0;
        end else if (wait_q == WAIT_LAST) begin
          set_to  = 1'b1;
          state_d = S_IDLE;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_WAIT_BL: begin
        if (!busy_s2_q) begin
          state_d = S_RD_LO;
          ch_d    = '0;
          cnt_d   = RDLO_LOAD;
          wait_d  = '0;
        end else if (wait_q == WAIT_LAST) begin
          set_to  = 1'b1;
          state_d = S_IDLE;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_RD_LO: begin
        if (cnt_q == '0) begin
          data_d  = adc_db;
          state_d = S_RD_HI;
          cnt_d   = RDHI_LOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RD_HI: begin
        // fifo_full is judged in the first RD_HI cycle; the registered
        // strobe follows one cycle later while fifo_data still holds the word.
        if (cnt_q == RDHI_LOAD) begin
          if (fifo_full) set_ovr = 1'b1;
          else           write_d = 1'b1;
        end
        if (cnt_q == '0) begin
          if (ch_q == CH_LAST) begin
            state_d = S_IDLE;
          end else begin
            ch_d    = ch_q + HW'(1);
            state_d = S_RD_LO;
            cnt_d   = RDLO_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A trigger outside IDLE is a lost sample period.
    if (trigger && (state_q != S_IDLE)) set_ovr = 1'b1;

    overrun_d = set_ovr | (overrun_q & ~clear_flags);
    timeout_d = set_to  | (timeout_q & ~clear_flags);

    // Bus outputs follow the next state so they are registered without lag.
    convst_d = (state_d == S_CONVST);
    cs_n_d   = !((state_d == S_RD_LO) || (state_d == S_RD_HI));
    rd_n_d   = (state_d != S_RD_LO);
    active_d = (state_d != S_IDLE);
  end

  assign adc_convst = convst_q;
  assign adc_cs_n   = cs_n_q;
  assign adc_rd_n   = rd_n_q;
  assign fifo_write = write_q;
  assign fifo_data  = data_q;
  assign overrun    = overrun_q;
  assign timeout    = timeout_q;
  assign active     = active_q;

endmodule
